// File: rtl/chain_bist_ctrl_if.sv
// Pin-side bundle of the chain BIST sequencer: run control, chain drive/return and result status.
// Optional first-fail status signals exist only when CHAIN_BIST_FIRSTFAIL_EN is defined.
interface chain_bist_ctrl_if #(
   parameter int LANES = 8
);
   logic             start;
   logic             abort;
   logic             pat_sel;
   logic [LANES-1:0] chain_dout;
   logic [LANES-1:0] chain_din;
   logic             busy;
   logic             done;
   logic             pass;
   logic [LANES-1:0] err_lane;
   logic [7:0]       err_count;
`ifdef CHAIN_BIST_FIRSTFAIL_EN
   logic [8:0]       first_fail;
   logic             first_valid;

   modport master (
      output start, abort, pat_sel, chain_dout,
      input  chain_din, busy, done, pass, err_lane, err_count, first_fail, first_valid
   );

   modport slave (
      input  start, abort, pat_sel, chain_dout,
      output chain_din, busy, done, pass, err_lane, err_count, first_fail, first_valid
   );
`else
   modport master (
      output start, abort, pat_sel, chain_dout,
      input  chain_din, busy, done, pass, err_lane, err_count
   );

   modport slave (
      input  start, abort, pat_sel, chain_dout,
      output chain_din, busy, done, pass, err_lane, err_count
   );
`endif
endinterface

// File: rtl/chain_bist_ctrl.sv
// BIST sequencer for the shift-register chain array: fills the chains for N cycles, then checks LEN cycles.
// Define CHAIN_BIST_FIRSTFAIL_EN to add first_fail/first_valid reporting of the first mismatching CHECK index.
module chain_bist_ctrl #(
   parameter int          N     = 80,
   parameter int          LANES = 8,
   parameter int          LEN   = 256,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input logic              clk,
   input logic              rst_n,
   chain_bist_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_CHECK = 2'd2
   } state_t;

   localparam logic [15:0] FILL_LAST  = 16'(N - 1);
   localparam logic [15:0] CHECK_LAST = 16'(LEN - 1);

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   function automatic logic [LANES-1:0] pattern(input logic [15:0] s, input logic ph, input logic sel);
      logic [LANES-1:0] p;
      p = {LANES{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         if (sel) begin
            p[i] = ph ^ ((i % 2) == 0);
         end else begin
            p[i] = s[4'(i % 16)];
         end
      end
      return p;
   endfunction

   state_t           state_q;
   logic             pat_sel_q;
   logic [15:0]      gen_lfsr_q;
   logic             gen_phase_q;
   logic [15:0]      chk_lfsr_q;
   logic             chk_phase_q;
   logic [15:0]      cnt_q;
   logic [LANES-1:0] chain_din_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [LANES-1:0] err_lane_q;
   logic [7:0]       err_count_q;
`ifdef CHAIN_BIST_FIRSTFAIL_EN
   logic [8:0]       first_fail_q;
   logic             first_valid_q;
`endif

   logic [LANES-1:0] gen_pat_s;
   logic [LANES-1:0] chk_pat_s;
   logic [LANES-1:0] start_pat_s;
   logic [LANES-1:0] mis_s;
   logic [LANES-1:0] err_lane_d;
   logic [7:0]       err_count_d;

   // Pattern generator/checker outputs and the per-cycle compare result.
   always_comb begin
      gen_pat_s   = pattern(gen_lfsr_q, gen_phase_q, pat_sel_q);
      chk_pat_s   = pattern(chk_lfsr_q, chk_phase_q, pat_sel_q);
      start_pat_s = pattern(SEED, 1'b0, bus.pat_sel);
      mis_s       = bus.chain_dout ^ chk_pat_s;
      err_lane_d  = err_lane_q | mis_s;
      if ((mis_s != {LANES{1'b0}}) && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end else begin
         err_count_d = err_count_q;
      end
   end

   // Run sequencer: chain_din_q always carries the step GEN produced last, gen_*_q the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         pat_sel_q     <= 1'b0;
         gen_lfsr_q    <= SEED;
         gen_phase_q   <= 1'b0;
         chk_lfsr_q    <= SEED;
         chk_phase_q   <= 1'b0;
         cnt_q         <= 16'd0;
         chain_din_q   <= {LANES{1'b0}};
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         err_lane_q    <= {LANES{1'b0}};
         err_count_q   <= 8'd0;
`ifdef CHAIN_BIST_FIRSTFAIL_EN
         first_fail_q  <= 9'd0;
         first_valid_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         if (bus.abort) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            cnt_q       <= 16'd0;
            chain_din_q <= {LANES{1'b0}};
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (bus.start) begin
                     pat_sel_q     <= bus.pat_sel;
                     chain_din_q   <= start_pat_s;
                     gen_lfsr_q    <= lfsr_next(SEED);
                     gen_phase_q   <= 1'b1;
                     chk_lfsr_q    <= SEED;
                     chk_phase_q   <= 1'b0;
                     err_lane_q    <= {LANES{1'b0}};
                     err_count_q   <= 8'd0;
                     pass_q        <= 1'b0;
                     busy_q        <= 1'b1;
                     cnt_q         <= 16'd0;
                     state_q       <= S_FILL;
`ifdef CHAIN_BIST_FIRSTFAIL_EN
                     first_fail_q  <= 9'd0;
                     first_valid_q <= 1'b0;
`endif
                  end else begin
                     chain_din_q <= {LANES{1'b0}};
                     busy_q      <= 1'b0;
                  end
               end
               S_FILL: begin
                  chain_din_q <= gen_pat_s;
                  gen_lfsr_q  <= lfsr_next(gen_lfsr_q);
                  gen_phase_q <= ~gen_phase_q;
                  if (cnt_q == FILL_LAST) begin
                     cnt_q   <= 16'd0;
                     state_q <= S_CHECK;
                  end else begin
                     cnt_q <= cnt_q + 16'd1;
                  end
               end
               S_CHECK: begin
                  err_lane_q  <= err_lane_d;
                  err_count_q <= err_count_d;
                  chk_lfsr_q  <= lfsr_next(chk_lfsr_q);
                  chk_phase_q <= ~chk_phase_q;
`ifdef CHAIN_BIST_FIRSTFAIL_EN
                  if (!first_valid_q && (mis_s != {LANES{1'b0}})) begin
                     first_fail_q  <= cnt_q[8:0];
                     first_valid_q <= 1'b1;
                  end
`endif
                  if (cnt_q == CHECK_LAST) begin
                     state_q     <= S_IDLE;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     pass_q      <= (err_lane_d == {LANES{1'b0}});
                     chain_din_q <= {LANES{1'b0}};
                     cnt_q       <= 16'd0;
                  end else begin
                     chain_din_q <= gen_pat_s;
                     gen_lfsr_q  <= lfsr_next(gen_lfsr_q);
                     gen_phase_q <= ~gen_phase_q;
                     cnt_q       <= cnt_q + 16'd1;
                  end
               end
               default: begin
                  state_q     <= S_IDLE;
                  busy_q      <= 1'b0;
                  cnt_q       <= 16'd0;
                  chain_din_q <= {LANES{1'b0}};
               end
            endcase
         end
      end
   end

   assign bus.chain_din   = chain_din_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.pass        = pass_q;
   assign bus.err_lane    = err_lane_q;
   assign bus.err_count   = err_count_q;
`ifdef CHAIN_BIST_FIRSTFAIL_EN
   assign bus.first_fail  = first_fail_q;
   assign bus.first_valid = first_valid_q;
`endif

endmodule

// File: tb/tb_chain_bist_ctrl.sv
// Self-checking bench for chain_bist_ctrl: chain array model, per-cycle reference model, directed and random runs.
module tb_chain_bist_ctrl;
   localparam int N     = 80;
   localparam int LANES = 8;
   localparam int LEN   = 256;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   chain_bist_ctrl_if #(.LANES(LANES)) bus();

   chain_bist_ctrl #(.N(N), .LANES(LANES), .LEN(LEN), .SEED(16'hACE1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Chain array model: 81 stages, tap 80 (ideal) or 81 (off by one), plus injected faults.
   logic [81*8-1:0] sr;
   logic [7:0]      corrupt;
   logic [7:0]      stuck0;
   logic [7:0]      stuck1;
   logic            deep;

   always @(posedge clk) sr <= {sr[80*8-1:0], bus.chain_din ^ corrupt};
   assign bus.chain_dout = ((deep ? sr[80*8 +: 8] : sr[79*8 +: 8]) & ~stuck0) | stuck1;

   // Reference model state: run position, expected pattern sequence and result registers.
   logic       m_act;
   int         m_t;
   logic       m_done;
   logic       m_pass;
   logic [7:0] m_lane;
   logic [7:0] m_cnt;
   logic [7:0] m_din;
   logic [8:0] m_ff;
   logic       m_fv;
   logic [7:0] m_pat [0:N+LEN-1];

   function automatic logic [7:0] gen_pat(input logic sel, input int step);
      int s;
      s = 32'hACE1;
      if (sel) return ((step % 2) == 0) ? 8'h55 : 8'hAA;
      for (int j = 0; j < step; j++)
         s = ((s << 1) | (((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 32'd1)) & 32'hFFFF;
      return s[7:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_act = 1'b0; m_t = 0; m_done = 1'b0; m_pass = 1'b0;
      m_lane = 8'h00; m_cnt = 8'h00; m_din = 8'h00; m_ff = 9'd0; m_fv = 1'b0;
   endtask

   task automatic model_advance();
      logic [7:0] mis;
      m_done = 1'b0;
      if (bus.abort) begin
         m_act  = 1'b0;
         m_pass = 1'b0;
      end else if (m_act) begin
         if (m_t >= N) begin
            mis    = bus.chain_dout ^ m_pat[m_t - N];
            m_lane = m_lane | mis;
            if (mis != 8'h00 && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
            if (mis != 8'h00 && !m_fv) begin
               m_fv = 1'b1;
               m_ff = 9'(m_t - N);
            end
         end
         if (m_t == N + LEN - 1) begin
            m_act  = 1'b0;
            m_done = 1'b1;
            m_pass = (m_lane == 8'h00);
         end else begin
            m_t++;
         end
      end else if (bus.start) begin
         for (int j = 0; j < N + LEN; j++) m_pat[j] = gen_pat(bus.pat_sel, j);
         m_act = 1'b1; m_t = 0; m_lane = 8'h00; m_cnt = 8'h00; m_pass = 1'b0;
         m_fv = 1'b0; m_ff = 9'd0;
      end
      m_din = m_act ? m_pat[m_t] : 8'h00;
   endtask

   function automatic logic [63:0] dut_vec();
      logic [63:0] v;
      v = 64'd0;
      v[26:0] = {bus.busy, bus.done, bus.pass, bus.chain_din, bus.err_lane, bus.err_count};
`ifdef CHAIN_BIST_FIRSTFAIL_EN
      v[36:27] = {bus.first_valid, bus.first_fail};
`endif
      return v;
   endfunction

   function automatic logic [63:0] model_vec();
      logic [63:0] v;
      v = 64'd0;
      v[26:0] = {m_act, m_done, m_pass, m_din, m_lane, m_cnt};
`ifdef CHAIN_BIST_FIRSTFAIL_EN
      v[36:27] = {m_fv, m_ff};
`endif
      return v;
   endfunction

   // One clock: compare on the falling edge, advance the model with the inputs the DUT will sample.
   task automatic tick();
      @(negedge clk);
      if (!rst_n) model_reset();
      chk("cycle", dut_vec(), model_vec());
      if (rst_n) model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic do_run(input logic sel, input int restart_at, input int abort_at, input int rst_at,
                         input int flip_at, input logic [7:0] flip_mask, input int noise,
                         output int bc, output logic done_seen, output logic [7:0] din0);
      logic ended;
      bc = 0; done_seen = 1'b0; din0 = 8'h00; ended = 1'b0;
      bus.pat_sel = sel;
      bus.start   = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (!bus.busy) begin
            done_seen = bus.done;
            ended     = 1'b1;
            break;
         end
         bc++;
         if (k == 0) din0 = bus.chain_din;
         if (k == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk("rst_mid", 64'(dut_vec()), 64'd0);
            tick();
            tick();
            rst_n = 1'b1;
            ended = 1'b1;
            break;
         end
         if (k == restart_at) bus.start = 1'b1;
         if (k == abort_at) bus.abort = 1'b1;
         if (noise != 0 && $urandom_range(0, noise - 1) == 0) bus.start = 1'b1;
         if (k == flip_at) corrupt = flip_mask;
         else if (noise != 0 && $urandom_range(0, noise - 1) == 0) corrupt = 8'($urandom_range(1, 255));
         tick();
         bus.start = 1'b0;
         bus.abort = 1'b0;
         corrupt   = 8'h00;
      end
      if (!ended) chk("run_timeout", {63'd0, bus.busy}, 64'd0);
      tick();
   endtask

   initial begin
      int         bc;
      logic       dn;
      logic [7:0] d0;
      logic [7:0] p;
      int         exp_cnt;

      total = 0; bad = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.pat_sel = 1'b0;
      corrupt = 8'h00; stuck0 = 8'h00; stuck1 = 8'h00; deep = 1'b0;
      model_reset();
      tick();
      chk("reset_outs", dut_vec(), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();

      chk("pin_lfsr0", {56'd0, gen_pat(1'b0, 0)}, 64'hE1);
      chk("pin_lfsr1", {56'd0, gen_pat(1'b0, 1)}, 64'hC3);
      chk("pin_chk0",  {56'd0, gen_pat(1'b1, 0)}, 64'h55);
      chk("pin_chk1",  {56'd0, gen_pat(1'b1, 1)}, 64'hAA);

      // Ideal chain, LFSR pattern.
      do_run(1'b0, -1, -1, -1, -1, 8'h00, 0, bc, dn, d0);
      chk("ideal_busy_len", 64'(bc), 64'd336);
      chk("ideal_done", {63'd0, dn}, 64'd1);
      chk("ideal_din0", {56'd0, d0}, 64'hE1);
      chk("ideal_result", {54'd0, bus.pass, bus.err_lane, bus.err_count}, {54'd0, 1'b1, 8'h00, 8'h00});

      // Re-pulsed start at busy cycle 100 is ignored.
      do_run(1'b1, 100, -1, -1, -1, 8'h00, 0, bc, dn, d0);
      chk("restart_busy_len", 64'(bc), 64'd336);
      chk("restart_done", {63'd0, dn}, 64'd1);
      chk("restart_pass", {63'd0, bus.pass}, 64'd1);

      // Lane 3 stuck at 0.
      stuck0 = 8'h08;
      do_run(1'b0, -1, -1, -1, -1, 8'h00, 0, bc, dn, d0);
      stuck0 = 8'h00;
      exp_cnt = 0;
      for (int i = 0; i < LEN; i++) begin
         p = gen_pat(1'b0, i);
         if (p[3]) exp_cnt++;
      end
      if (exp_cnt > 255) exp_cnt = 255;
      chk("stuck3_lane", {56'd0, bus.err_lane}, 64'h08);
      chk("stuck3_count", {56'd0, bus.err_count}, 64'(exp_cnt));
      chk("stuck3_pass", {63'd0, bus.pass}, 64'd0);

      // Chain one flop too deep, checkerboard.
      deep = 1'b1;
      do_run(1'b1, -1, -1, -1, -1, 8'h00, 0, bc, dn, d0);
      deep = 1'b0;
      chk("deep_result", {47'd0, bus.pass, bus.err_lane, bus.err_count}, {47'd0, 1'b0, 8'hFF, 8'hFF});

      // Abort at busy cycle 50.
      do_run(1'b0, -1, 50, -1, -1, 8'h00, 0, bc, dn, d0);
      chk("abort_busy_len", 64'(bc), 64'd51);
      chk("abort_no_done", {63'd0, dn}, 64'd0);
      chk("abort_outs", {54'd0, bus.busy, bus.pass, bus.chain_din}, 64'd0);

      // Reset at busy cycle 200, then a clean run.
      do_run(1'b0, -1, -1, 200, -1, 8'h00, 0, bc, dn, d0);
      do_run(1'b0, -1, -1, -1, -1, 8'h00, 0, bc, dn, d0);
      chk("post_rst_len", 64'(bc), 64'd336);
      chk("post_rst_pass", {63'd0, bus.pass}, 64'd1);

      // Lane 0 wrong only at CHECK index 17.
      do_run(1'b0, -1, -1, -1, 17, 8'h01, 0, bc, dn, d0);
      chk("flip17_result", {47'd0, bus.pass, bus.err_lane, bus.err_count}, {47'd0, 1'b0, 8'h01, 8'h01});
`ifdef CHAIN_BIST_FIRSTFAIL_EN
      chk("flip17_first", {54'd0, bus.first_valid, bus.first_fail}, {54'd0, 1'b1, 9'd17});
`endif

      // Randomized runs checked cycle by cycle against the model.
      for (int r = 0; r < 8; r++) begin
         stuck0 = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         stuck1 = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         deep   = ($urandom_range(0, 4) == 0);
         do_run(1'($urandom_range(0, 1)), -1,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 335)) : -1,
                -1, -1, 8'h00, ($urandom_range(0, 1) == 0) ? 0 : 40, bc, dn, d0);
         tick();
      end
      stuck0 = 8'h00; stuck1 = 8'h00; deep = 1'b0;
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
